// File: rtl/kgp_exec_pkg.sv
// kgp_exec_pkg: constants shared by the KGP-RISC execute/branch unit.
//   - alu_op classes, R-type func codes, ALU control codes (enum)
//   - branch classes and conditional-branch func codes
//   - flag bit indices inside flags[2:0] = {carry, zero, sign}
// Optional feature macro: KGP_EXEC_SUB_EN (SUB counts as a carry producer).
package kgp_exec_pkg;

  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_COMP  = 3'b010;

  localparam logic [5:0] FN_ADD   = 6'd0;
  localparam logic [5:0] FN_COMP  = 6'd1;
  localparam logic [5:0] FN_AND   = 6'd2;
  localparam logic [5:0] FN_XOR   = 6'd3;
  localparam logic [5:0] FN_SHLL  = 6'd4;
  localparam logic [5:0] FN_SHRL  = 6'd5;
  localparam logic [5:0] FN_SHLLV = 6'd6;
  localparam logic [5:0] FN_SHRLV = 6'd7;
  localparam logic [5:0] FN_SHRA  = 6'd8;
  localparam logic [5:0] FN_SHRAV = 6'd9;
  localparam logic [5:0] FN_SUB   = 6'd10;

  typedef enum logic [3:0] {
    CTL_ADD   = 4'b0000,
    CTL_COMP  = 4'b0001,
    CTL_AND   = 4'b0010,
    CTL_XOR   = 4'b0011,
    CTL_SHLL  = 4'b0100,
    CTL_SHRL  = 4'b0101,
    CTL_SHLLV = 4'b0110,
    CTL_SHRLV = 4'b0111,
    CTL_SHRA  = 4'b1000,
    CTL_SHRAV = 4'b1001,
    CTL_SUB   = 4'b1010,
    CTL_NOP   = 4'b1111
  } alu_ctl_e;

  localparam logic [1:0] BR_SEQ  = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_REG  = 2'b10;
  localparam logic [1:0] BR_LINK = 2'b11;

  localparam logic [5:0] BC_B    = 6'd0;
  localparam logic [5:0] BC_BLTZ = 6'd1;
  localparam logic [5:0] BC_BZ   = 6'd2;
  localparam logic [5:0] BC_BNZ  = 6'd3;
  localparam logic [5:0] BC_BCY  = 6'd4;
  localparam logic [5:0] BC_BNCY = 6'd5;

  localparam int FLAG_CY = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_S  = 0;

  // Operations whose carry is captured by the sticky carry register.
  function automatic logic is_carry_op(input alu_ctl_e c);
`ifdef KGP_EXEC_SUB_EN
    return (c == CTL_ADD) || (c == CTL_COMP) || (c == CTL_SUB);
`else
    return (c == CTL_ADD) || (c == CTL_COMP);
`endif
  endfunction

endpackage

// File: rtl/kgp_alu_core.sv
// kgp_alu_core: combinational 32-bit ALU datapath plus flags.
//   ctl    : decoded ALU control code
//   a, b   : operands (b also supplies the variable shift amount)
//   shamt  : fixed shift amount
//   result : ALU result
//   flags  : {carry, zero, sign}
// Optional feature macro: KGP_EXEC_SUB_EN (enables SUB datapath).
import kgp_exec_pkg::*;

module kgp_alu_core #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  alu_ctl_e            ctl,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [SHAMT_W-1:0]  shamt,
  output logic [DATA_W-1:0]   result,
  output logic [2:0]          flags
);

  logic [DATA_W:0]    sum;
  logic [SHAMT_W-1:0] vsh;
  logic               carry;

  assign sum = {1'b0, a} + {1'b0, b};
  assign vsh = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (ctl)
      CTL_ADD:   {carry, result} = sum;
      CTL_COMP: begin
        result = ~b + DATA_W'(1);
        carry  = (b == '0);
      end
      CTL_AND:   result = a & b;
      CTL_XOR:   result = a ^ b;
      CTL_SHLL:  result = a << shamt;
      CTL_SHRL:  result = a >> shamt;
      CTL_SHLLV: result = a << vsh;
      CTL_SHRLV: result = a >> vsh;
      CTL_SHRA:  result = $signed(a) >>> shamt;
      CTL_SHRAV: result = $signed(a) >>> vsh;
`ifdef KGP_EXEC_SUB_EN
      // a + ~b + 1: bit DATA_W is set exactly when no borrow (a >= b).
      CTL_SUB:   {carry, result} = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
`endif
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign flags = {carry, (result == '0), result[DATA_W-1]};

endmodule

// File: rtl/kgp_exec_branch_unit.sv
// kgp_exec_branch_unit: KGP-RISC execute stage -- ALU-control decode, ALU,
// sticky carry register and next-PC / branch resolution.
//   clk, rst           : clock, async active-low reset
//   alu_op, func_code  : operation class and R-type/branch function
//   input1, input2     : rs value, rt value or sign-extended immediate
//   shamt              : fixed shift amount
//   branch             : branch class (seq / cond / br / bl)
//   pc_in, dest_addr   : current PC, absolute branch target
//   alu_control_signal : decoded ALU op
//   alu_out, flags     : ALU result and {carry, zero, sign}
//   pc_out             : next PC
//   link_ref           : link value pc_in+PC_STEP ("ref" is a reserved word)
// Optional feature macro: KGP_EXEC_SUB_EN (func_code 10 decodes to SUB).
import kgp_exec_pkg::*;

module kgp_exec_branch_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int PC_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         alu_op,
  input  logic [5:0]         func_code,
  input  logic [DATA_W-1:0]  input1,
  input  logic [DATA_W-1:0]  input2,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         branch,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic [DATA_W-1:0]  dest_addr,
  output logic [3:0]         alu_control_signal,
  output logic [DATA_W-1:0]  alu_out,
  output logic [2:0]         flags,
  output logic [DATA_W-1:0]  pc_out,
  output logic [DATA_W-1:0]  link_ref
);

  alu_ctl_e          ctl;
  logic              cy_q;
  logic              taken;
  logic [DATA_W-1:0] seq_pc;
  logic [DATA_W-1:0] nxt_pc;

  always_comb begin
    ctl = CTL_NOP;
    case (alu_op)
      ALUOP_RTYPE: begin
        case (func_code)
          FN_ADD:   ctl = CTL_ADD;
          FN_COMP:  ctl = CTL_COMP;
          FN_AND:   ctl = CTL_AND;
          FN_XOR:   ctl = CTL_XOR;
          FN_SHLL:  ctl = CTL_SHLL;
          FN_SHRL:  ctl = CTL_SHRL;
          FN_SHLLV: ctl = CTL_SHLLV;
          FN_SHRLV: ctl = CTL_SHRLV;
          FN_SHRA:  ctl = CTL_SHRA;
          FN_SHRAV: ctl = CTL_SHRAV;
`ifdef KGP_EXEC_SUB_EN
          FN_SUB:   ctl = CTL_SUB;
`endif
          default:  ctl = CTL_NOP;
        endcase
      end
      ALUOP_ADD:  ctl = CTL_ADD;
      ALUOP_COMP: ctl = CTL_COMP;
      default:    ctl = CTL_NOP;
    endcase
  end

  assign alu_control_signal = ctl;

  kgp_alu_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .ctl    (ctl),
    .a      (input1),
    .b      (input2),
    .shamt  (shamt),
    .result (alu_out),
    .flags  (flags)
  );

  // Carry seen by bcy/bncy is always from an earlier instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cy_q <= 1'b0;
    else if (is_carry_op(ctl)) cy_q <= flags[FLAG_CY];
  end

  always_comb begin
    taken = 1'b0;
    case (func_code)
      BC_B:    taken = 1'b1;
      BC_BLTZ: taken = input1[DATA_W-1];
      BC_BZ:   taken = (input1 == '0);
      BC_BNZ:  taken = (input1 != '0);
      BC_BCY:  taken = cy_q;
      BC_BNCY: taken = !cy_q;
      default: taken = 1'b0;
    endcase
  end

  assign seq_pc = pc_in + DATA_W'(PC_STEP);

  always_comb begin
    nxt_pc = seq_pc;
    case (branch)
      BR_SEQ:  nxt_pc = seq_pc;
      BR_COND: nxt_pc = taken ? dest_addr : seq_pc;
      BR_REG:  nxt_pc = input1;
      BR_LINK: nxt_pc = dest_addr;
      default: nxt_pc = seq_pc;
    endcase
  end

  // Reset overrides combinationally so the PC register sees 0 at once.
  assign pc_out   = rst ? nxt_pc : '0;
  assign link_ref = rst ? seq_pc : DATA_W'(PC_STEP);

endmodule

// File: tb/tb_kgp_exec_branch_unit.sv
module tb_kgp_exec_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_op;
  logic [5:0]  func_code;
  logic [31:0] input1, input2, pc_in, dest_addr;
  logic [4:0]  shamt;
  logic [1:0]  branch;
  logic [3:0]  alu_control_signal;
  logic [31:0] alu_out, pc_out, link_ref;
  logic [2:0]  flags;

  int n_chk  = 0;
  int n_fail = 0;

  kgp_exec_branch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .alu_op             (alu_op),
    .func_code          (func_code),
    .input1             (input1),
    .input2             (input2),
    .shamt              (shamt),
    .branch             (branch),
    .pc_in              (pc_in),
    .dest_addr          (dest_addr),
    .alu_control_signal (alu_control_signal),
    .alu_out            (alu_out),
    .flags              (flags),
    .pc_out             (pc_out),
    .link_ref           (link_ref)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; alu_op = 3'd3; func_code = 6'd0; input1 = '0; input2 = '0;
    shamt = '0; branch = 2'b11; pc_in = 32'h8; dest_addr = 32'h40;
    #2;
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_ref", link_ref, 32'h4);

    @(negedge clk); rst = 1'b1; branch = 2'b00; #1;
    chk("seq_pc", pc_out, 32'd12);
    chk("seq_ref", link_ref, 32'd12);
    branch = 2'b01; func_code = 6'd4; #1;
    chk("bcy_after_rst", pc_out, 32'd12);

    // R-type add with carry out
    branch = 2'b00; alu_op = 3'd0; func_code = 6'd0;
    input1 = 32'hFFFF_FFFF; input2 = 32'h1; #1;
    chk("add_ctl", {28'd0, alu_control_signal}, 32'h0);
    chk("add_out", alu_out, 32'h0);
    chk("add_flags", {29'd0, flags}, 32'h6);
    @(negedge clk);
    alu_op = 3'd3; branch = 2'b01; func_code = 6'd4; pc_in = 32'h100; dest_addr = 32'h200; #1;
    chk("bcy_taken", pc_out, 32'h200);
    func_code = 6'd5; #1;
    chk("bncy_not_taken", pc_out, 32'h104);

    // undefined decode holds cy_q
    branch = 2'b00; alu_op = 3'd0; func_code = 6'd63; #1;
    chk("undef_ctl", {28'd0, alu_control_signal}, 32'hF);
    chk("undef_out", alu_out, 32'h0);
    @(negedge clk);
    alu_op = 3'd3; branch = 2'b01; func_code = 6'd4; #1;
    chk("bcy_hold", pc_out, 32'h200);

    // shifts
    branch = 2'b00; alu_op = 3'd0; input1 = 32'h8000_0000; shamt = 5'd4;
    func_code = 6'd8; #1;
    chk("shra", alu_out, 32'hF800_0000);
    chk("shra_flags", {29'd0, flags}, 32'h1);
    func_code = 6'd5; #1;
    chk("shrl", alu_out, 32'h0800_0000);
    func_code = 6'd4; #1;
    chk("shll", alu_out, 32'h0);
    input1 = 32'h0000_0003; input2 = 32'd33; func_code = 6'd6; #1;
    chk("shllv", alu_out, 32'h6);
    input1 = 32'h8000_0000; input2 = 32'd36; func_code = 6'd9; #1;
    chk("shrav", alu_out, 32'hF800_0000);
    func_code = 6'd7; #1;
    chk("shrlv", alu_out, 32'h0800_0000);
    shamt = 5'd0; func_code = 6'd8; #1;
    chk("shra_zero", alu_out, 32'h8000_0000);

    // logic ops
    input1 = 32'hF0F0_1234; input2 = 32'h0FF0_FFFF; func_code = 6'd2; #1;
    chk("and", alu_out, 32'h00F0_1234);
    func_code = 6'd3; #1;
    chk("xor", alu_out, 32'hFF00_EDCB);

    // compi
    alu_op = 3'd2; input2 = 32'd5; #1;
    chk("comp_ctl", {28'd0, alu_control_signal}, 32'h1);
    chk("comp_out", alu_out, 32'hFFFF_FFFB);
    chk("comp_flags", {29'd0, flags}, 32'h1);
    @(negedge clk);
    alu_op = 3'd3; branch = 2'b01; func_code = 6'd4; #1;
    chk("bcy_cleared", pc_out, 32'h104);
    alu_op = 3'd2; branch = 2'b00; input2 = 32'd0; #1;
    chk("comp0_out", alu_out, 32'h0);
    chk("comp0_flags", {29'd0, flags}, 32'h6);

    // alu_op ADD class (addi)
    alu_op = 3'd1; input1 = 32'd10; input2 = 32'hFFFF_FFFE; #1;
    chk("addi_out", alu_out, 32'd8);
    chk("addi_flags", {29'd0, flags}, 32'h4);
    alu_op = 3'd5; #1;
    chk("nop_class", {28'd0, alu_control_signal}, 32'hF);

    // conditional branches on input1
    alu_op = 3'd3; branch = 2'b01; input1 = 32'd0;
    func_code = 6'd2; #1;
    chk("bz_taken", pc_out, 32'h200);
    func_code = 6'd3; #1;
    chk("bnz_not", pc_out, 32'h104);
    input1 = 32'hFFFF_FFFD; func_code = 6'd1; #1;
    chk("bltz_taken", pc_out, 32'h200);
    func_code = 6'd2; #1;
    chk("bz_not", pc_out, 32'h104);
    func_code = 6'd0; #1;
    chk("b_taken", pc_out, 32'h200);
    func_code = 6'd9; #1;
    chk("cond_undef", pc_out, 32'h104);
    branch = 2'b10; input1 = 32'h100; #1;
    chk("br", pc_out, 32'h100);
    branch = 2'b11; pc_in = 32'h20; #1;
    chk("bl_pc", pc_out, 32'h200);
    chk("bl_ref", link_ref, 32'h24);
    pc_in = 32'hFFFF_FFFC; branch = 2'b00; #1;
    chk("ref_wrap", link_ref, 32'h0);
    chk("pc_wrap", pc_out, 32'h0);

    // SUB option
    alu_op = 3'd0; func_code = 6'd10; input1 = 32'd7; input2 = 32'd9; #1;
`ifdef KGP_EXEC_SUB_EN
    chk("sub_ctl", {28'd0, alu_control_signal}, 32'hA);
    chk("sub_out", alu_out, 32'hFFFF_FFFE);
    chk("sub_flags", {29'd0, flags}, 32'h1);
    input1 = 32'd9; input2 = 32'd7; #1;
    chk("sub_nb_flags", {29'd0, flags}, 32'h4);
`else
    chk("sub_off_ctl", {28'd0, alu_control_signal}, 32'hF);
    chk("sub_off_out", alu_out, 32'h0);
`endif

    // set carry, then async reset mid-cycle clears it and pc_out
    alu_op = 3'd1; input1 = 32'hFFFF_FFFF; input2 = 32'h2; branch = 2'b11;
    pc_in = 32'h40; dest_addr = 32'h80;
    @(negedge clk);
    alu_op = 3'd3; #2;
    rst = 1'b0; #1;
    chk("async_rst_pc", pc_out, 32'h0);
    #1 rst = 1'b1; branch = 2'b01; func_code = 6'd4; #1;
    chk("async_rst_cy", pc_out, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kgp_exec_branch_unit.md
Name: kgp_exec_branch_unit

Overview:
- Execute-stage core of the KGP-RISC single-cycle processor. Merges three functions: ALU-control decode, the 32-bit ALU, and next-PC/branch resolution.
- Sits between the register file / main control and the PC register / instruction fetcher.
- Everything is combinational except a sticky carry register, which serves bcy/bncy.

Parameters:
- DATA_W, 32, datapath and PC width.
- SHAMT_W, 5, shift-amount width.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock; carry register updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_op  in  3  class from main control.
- func_code  in  6  instr[5:0].
- input1  in  DATA_W  rs value; also the branch register operand.
- input2  in  DATA_W  rt value or sign-extended immediate.
- shamt  in  SHAMT_W  instr[10:6].
- branch  in  2  branch class from main control.
- pc_in  in  DATA_W  current PC.
- dest_addr  in  DATA_W  sign-extended branch target, as an absolute byte address.
- alu_control_signal  out  4  decoded ALU operation.
- alu_out  out  DATA_W  ALU result.
- flags  out  3  {carry, zero, sign} of the current result.
- pc_out  out  DATA_W  next PC.
- ref  out  DATA_W  link value, pc_in+PC_STEP.

Behaviour:
- Decode, alu_op:
  - 000: R-type, decoded from func_code.
  - 001: ADD (addi, lw, sw).
  - 010: COMP (compi).
  - 011..111: NOP.
- Decode, func_code (R-type):
  - 0 ADD, 1 COMP, 2 AND, 3 XOR.
  - 4 SHLL, 5 SHRL, 6 SHLLV, 7 SHRLV, 8 SHRA, 9 SHRAV.
  - Any other value: NOP.
- Control codes: ADD 0000, COMP 0001, AND 0010, XOR 0011, SHLL 0100, SHRL 0101, SHLLV 0110, SHRLV 0111, SHRA 1000, SHRAV 1001, SUB 1010, NOP 1111.
- ALU operations:
  - ADD: input1+input2; carry = bit 32 of the 33-bit sum.
  - COMP: ~input2+1; carry = 1 only when input2==0.
  - AND, XOR: bitwise.
  - Fixed shifts use shamt. Variable shifts use input2[4:0] only.
  - SHRA/SHRAV are arithmetic (sign-fill); other shifts zero-fill. Shift by 0 gives input1.
  - NOP: alu_out=0.
  - carry=0 for every operation other than ADD, COMP and SUB.
  - zero = (alu_out==0); sign = alu_out[31].
- Sticky carry register (cy_q):
  - Async cleared to 0 when rst=0.
  - On a rising clk, loads the current carry if the control code is ADD, COMP or SUB; otherwise holds.
  - bcy/bncy test cy_q, i.e. the carry of the most recent earlier carry-producing instruction, never the same cycle's ALU.
- Next PC, selected by branch:
  - 00: pc_in+PC_STEP.
  - 01: conditional family by func_code:
    - 0 b: always taken.
    - 1 bltz: taken if input1[31].
    - 2 bz: taken if input1==0.
    - 3 bnz: taken if input1!=0.
    - 4 bcy: taken if cy_q.
    - 5 bncy: taken if !cy_q.
    - Any other value: not taken.
    - Taken gives dest_addr; not taken gives pc_in+PC_STEP.
  - 10: br, pc_out = input1.
  - 11: bl, pc_out = dest_addr.
- ref = pc_in+PC_STEP always (wraps modulo 2^DATA_W). Main control decides whether it is written.
- Condition tests use input1 directly, independent of the ALU result.
- While rst=0: pc_out=0, ref=PC_STEP, cy_q=0. ALU outputs stay combinational.
- Reset asserted mid-operation forces pc_out=0 immediately, without waiting for a clock.
- All additions wrap modulo 2^DATA_W.

Optional Feature:
- Macro KGP_EXEC_SUB_EN.
- When defined: func_code 10 decodes to SUB (1010), computing input1-input2. carry = 1 when no borrow (input1 >= input2, unsigned), and SUB updates cy_q.
- When undefined: func_code 10 decodes to NOP, and code 1010 behaves as NOP.

Decomposition:
- Shared package kgp_exec_pkg holds:
  - alu_op, func_code and control-code constants.
  - Branch class codes (00/01/10/11) and conditional func codes (0..5).
  - Flag bit indices (2 carry, 1 zero, 0 sign).
- One natural sub-module: kgp_alu_core, the combinational datapath plus flags. Decode and next-PC logic live in the top.

Test Plan:
- Reset: rst=0 with branch=11, dest_addr=0x40 -> pc_out=0, cy_q=0. After release with branch=00, pc_in=8 -> pc_out=12, ref=12.
- R-type add: alu_op=000, func=0, input1=0xFFFFFFFF, input2=1 -> alu_out=0, flags=3'b110.
  - Then clock; next cycle branch=01, func=4 -> pc_out=dest_addr.
  - Then bncy (func=5) -> pc_out=pc_in+4.
- Shifts: input1=0x80000000, shamt=4 -> SHRA gives 0xF8000000, SHRL gives 0x08000000. SHLLV with input2=33 -> input1<<1.
- compi/COMP: alu_op=010, input2=5 -> alu_out=0xFFFFFFFB, sign=1, carry=0. input2=0 -> alu_out=0, carry=1.
- Conditional branches:
  - input1=0: bz taken, bnz not taken.
  - input1=-3: bltz taken.
  - br: input1=0x100 -> pc_out=0x100.
  - bl: pc_in=0x20 -> pc_out=dest_addr, ref=0x24.
- Undefined decode: alu_op=000, func=63 -> control 1111, alu_out=0, cy_q unchanged across a clock. With KGP_EXEC_SUB_EN: func=10, 7-9 -> 0xFFFFFFFE, carry=0.
